// File: rtl/scoreboard_btn_cond.sv
// Scoreboard button conditioner: per-channel 2-flop sync, debounce, press
// detection and long-press detection. Channels are fully independent.
module scoreboard_btn_cond #(
  parameter int N_BTN      = 9,
  parameter int DEB_COUNT  = 500000,
  parameter int LONG_COUNT = 50000000,
  parameter int CNT_W      = 26
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  input  logic [N_BTN-1:0] btn_raw_i,
  input  logic             deb_bypass_i,
  output logic [N_BTN-1:0] btn_level_o,
  output logic [N_BTN-1:0] btn_press_o,
  output logic [N_BTN-1:0] btn_long_o,
  output logic             btn_any_o
);

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_COUNT - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_COUNT - 1);
  localparam logic [CNT_W-1:0] LONG_MAX  = CNT_W'(LONG_COUNT);

  logic [N_BTN-1:0] sync_q1;
  logic [N_BTN-1:0] sync_q2;
  logic [N_BTN-1:0] level_d;
  logic [CNT_W-1:0] deb_cnt   [N_BTN];
  logic [CNT_W-1:0] deb_cnt_d [N_BTN];
  logic [CNT_W-1:0] hold_cnt  [N_BTN];

  // Next debounced level: accept sync on the edge the mismatch streak hits DEB_COUNT.
  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      level_d[i]   = btn_level_o[i];
      deb_cnt_d[i] = '0;
      if (deb_bypass_i) begin
        level_d[i] = sync_q2[i];
      end else if (sync_q2[i] != btn_level_o[i]) begin
        if (deb_cnt[i] == DEB_LAST) begin
          level_d[i] = sync_q2[i];
        end else begin
          deb_cnt_d[i] = deb_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      sync_q1     <= '0;
      sync_q2     <= '0;
      btn_level_o <= '0;
      btn_press_o <= '0;
      btn_long_o  <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        deb_cnt[i]  <= '0;
        hold_cnt[i] <= '0;
      end
    end else begin
      sync_q1     <= btn_raw_i;
      sync_q2     <= sync_q1;
      btn_level_o <= level_d;
      btn_press_o <= level_d & ~btn_level_o;
      for (int i = 0; i < N_BTN; i++) begin
        deb_cnt[i] <= deb_cnt_d[i];
        // Hold counter saturates so the long pulse can fire only once per press.
        if (!btn_level_o[i]) begin
          hold_cnt[i] <= '0;
        end else if (hold_cnt[i] != LONG_MAX) begin
          hold_cnt[i] <= hold_cnt[i] + CNT_W'(1);
        end
        btn_long_o[i] <= btn_level_o[i] && (hold_cnt[i] == LONG_LAST);
      end
    end
  end

  assign btn_any_o = |btn_press_o;

endmodule

// File: tb/tb_scoreboard_btn_cond.sv
// Bench for scoreboard_btn_cond: directed scenarios plus randomized traffic,
// all compared against a cycle-level behavioural model of the button rules.
module tb_scoreboard_btn_cond;

  localparam int N    = 9;
  localparam int DEB  = 4;
  localparam int LONG = 10;
  localparam int CW   = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] btn_raw;
  logic         deb_bypass;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_press;
  logic [N-1:0] btn_long;
  logic         btn_any;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [N-1:0] m_s1, m_s2, m_level, m_press, m_long;
  int m_streak     [N];
  int m_high_since [N];
  int edge_no = 0;

  scoreboard_btn_cond #(
    .N_BTN(N), .DEB_COUNT(DEB), .LONG_COUNT(LONG), .CNT_W(CW)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_ni   (rst_n),
    .btn_raw_i   (btn_raw),
    .deb_bypass_i(deb_bypass),
    .btn_level_o (btn_level),
    .btn_press_o (btn_press),
    .btn_long_o  (btn_long),
    .btn_any_o   (btn_any)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_s1 = '0; m_s2 = '0; m_level = '0; m_press = '0; m_long = '0;
    for (int i = 0; i < N; i++) begin
      m_streak[i]     = 0;
      m_high_since[i] = 0;
    end
  endfunction

  // One rising edge of the model: the debouncer sees raw from two edges ago.
  function automatic void model_edge();
    logic nl;
    edge_no++;
    for (int i = 0; i < N; i++) begin
      nl = m_level[i];
      if (deb_bypass) begin
        nl = m_s2[i];
        m_streak[i] = 0;
      end else if (m_s2[i] != m_level[i]) begin
        m_streak[i]++;
        if (m_streak[i] == DEB) begin
          nl = m_s2[i];
          m_streak[i] = 0;
        end
      end else begin
        m_streak[i] = 0;
      end
      m_press[i] = nl & ~m_level[i];
      m_long[i]  = m_level[i] && (edge_no - m_high_since[i] == LONG);
      if (m_press[i]) m_high_since[i] = edge_no;
      m_level[i] = nl;
    end
    m_s2 = m_s1;
    m_s1 = btn_raw;
  endfunction

  task automatic apply_stimulus(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      if (rst_n) model_edge();
      #1;
      check_output("level", btn_level, m_level);
      check_output("press", btn_press, m_press);
      check_output("long",  btn_long,  m_long);
      check_output("any",   {{(N-1){1'b0}}, btn_any}, {{(N-1){1'b0}}, |m_press});
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_level"}, btn_level, '0);
    check_output({tag, "_press"}, btn_press, '0);
    check_output({tag, "_long"},  btn_long,  '0);
    check_output({tag, "_any"},   {{(N-1){1'b0}}, btn_any}, '0);
  endtask

  // Pull reset low between clocks, check it acts immediately, release after one edge.
  task automatic do_reset(input string tag);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all_zero(tag);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int first_e, cnt, any_hit, long_e, long_cnt, p_cnt, lvl_cnt, rate;
    logic [N-1:0] pvec;

    rst_n = 1'b0; btn_raw = '0; deb_bypass = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    apply_stimulus(3);

    // Clean press on channel 0
    btn_raw[0] = 1'b1;
    first_e = -1; cnt = 0; any_hit = 0;
    for (int e = 1; e <= 8; e++) begin
      apply_stimulus(1);
      if (btn_press[0]) begin
        cnt++;
        if (first_e < 0) first_e = e;
        any_hit = btn_any ? 1 : 0;
      end
    end
    check_int("press0_latency", first_e, 6);
    check_int("press0_count", cnt, 1);
    check_int("press0_any", any_hit, 1);
    btn_raw[0] = 1'b0;
    p_cnt = 0;
    for (int e = 1; e <= 10; e++) begin
      apply_stimulus(1);
      if (btn_any || (|btn_long)) p_cnt++;
    end
    check_int("release0_pulses", p_cnt, 0);

    // Three-cycle glitch on channel 3
    btn_raw[3] = 1'b1;
    lvl_cnt = 0; p_cnt = 0;
    for (int e = 1; e <= 14; e++) begin
      if (e == 4) btn_raw[3] = 1'b0;
      apply_stimulus(1);
      if (btn_level[3]) lvl_cnt++;
      if (btn_any || (|btn_press) || (|btn_long)) p_cnt++;
    end
    check_int("glitch_level3", lvl_cnt, 0);
    check_int("glitch_pulses", p_cnt, 0);

    // Long press on channel 8, then a short press
    btn_raw[8] = 1'b1;
    first_e = -1; long_e = -1; long_cnt = 0;
    for (int e = 1; e <= 26; e++) begin
      apply_stimulus(1);
      if (btn_press[8] && first_e < 0) first_e = e;
      if (btn_long[8]) begin
        long_cnt++;
        if (long_e < 0) long_e = e;
      end
    end
    check_int("press8_latency", first_e, 6);
    check_int("long8_delay", long_e - first_e, 10);
    check_int("long8_count", long_cnt, 1);
    btn_raw[8] = 1'b0;
    p_cnt = 0;
    for (int e = 1; e <= 10; e++) begin
      apply_stimulus(1);
      if (btn_any || (|btn_long)) p_cnt++;
    end
    check_int("release8_pulses", p_cnt, 0);
    btn_raw[8] = 1'b1;
    cnt = 0; long_cnt = 0;
    for (int e = 1; e <= 19; e++) begin
      if (e == 8) btn_raw[8] = 1'b0;
      apply_stimulus(1);
      if (btn_press[8]) cnt++;
      if (btn_long[8]) long_cnt++;
    end
    check_int("short8_press", cnt, 1);
    check_int("short8_long", long_cnt, 0);

    // All nine channels stepped together
    btn_raw = 9'h1FF;
    pvec = '0; cnt = 0; first_e = -1;
    for (int e = 1; e <= 8; e++) begin
      apply_stimulus(1);
      if (btn_any) begin
        cnt++;
        pvec = btn_press;
        if (first_e < 0) first_e = e;
      end
    end
    check_output("simul_press_vec", pvec, 9'h1FF);
    check_int("simul_any_count", cnt, 1);
    check_int("simul_latency", first_e, 6);
    btn_raw = '0;
    apply_stimulus(10);

    // Debounce bypass, one-cycle raw pulse on channel 1
    deb_bypass = 1'b1;
    apply_stimulus(2);
    btn_raw[1] = 1'b1;
    first_e = -1; lvl_cnt = 0; cnt = 0;
    for (int e = 1; e <= 6; e++) begin
      apply_stimulus(1);
      if (e == 1) btn_raw[1] = 1'b0;
      if (btn_level[1]) begin
        lvl_cnt++;
        if (first_e < 0) first_e = e;
      end
      if (btn_press[1]) cnt++;
    end
    check_int("bypass_latency", first_e, 3);
    check_int("bypass_level_cycles", lvl_cnt, 1);
    check_int("bypass_press_count", cnt, 1);
    deb_bypass = 1'b0;
    apply_stimulus(4);

    // Reset in the middle of a hold on channel 2
    btn_raw[2] = 1'b1;
    first_e = -1;
    for (int e = 1; e <= 6; e++) begin
      apply_stimulus(1);
      if (btn_press[2] && first_e < 0) first_e = e;
    end
    check_int("press2_latency", first_e, 6);
    apply_stimulus(3);
    do_reset("midhold");
    first_e = -1; long_e = -1;
    for (int e = 1; e <= 20; e++) begin
      apply_stimulus(1);
      if (btn_press[2] && first_e < 0) first_e = e;
      if (btn_long[2] && long_e < 0) long_e = e;
    end
    check_int("press2_after_reset", first_e, 6);
    check_int("long2_after_reset", long_e - first_e, 10);
    btn_raw[2] = 1'b0;
    apply_stimulus(10);

    // Randomized traffic with varying toggle rates, bypass flips and resets
    for (int blk = 0; blk < 15; blk++) begin
      rate = $urandom_range(30, 2);
      for (int c = 0; c < 200; c++) begin
        for (int i = 0; i < N; i++)
          if ($urandom_range(rate - 1) == 0) btn_raw[i] = ~btn_raw[i];
        if ($urandom_range(59) == 0) deb_bypass = ~deb_bypass;
        apply_stimulus(1);
        if ($urandom_range(299) == 0) do_reset("rand_reset");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scoreboard_btn_cond.md
SCOREBOARD_BTN_COND -- requirements
Module: scoreboard_btn_cond

Interface
REQ-001 Parameter N_BTN, default 9: number of button channels.
REQ-002 Parameter DEB_COUNT, default 500000: consecutive stable cycles needed to accept a level change (10 ms at 50 MHz).
REQ-003 Parameter LONG_COUNT, default 50000000: cycles a debounced press must be held to count as a long press (1 s at 50 MHz).
REQ-004 Parameter CNT_W, default 26: counter width; SHALL satisfy 2^CNT_W > max(DEB_COUNT, LONG_COUNT).
REQ-005 wb_clk_i  input  1  the single clock; all state is on its rising edge.
REQ-006 wb_rst_ni  input  1  asynchronous, active-low reset.
REQ-007 btn_raw_i  input  N_BTN  raw, asynchronous, active-high button pads (scoreboard pads io_in[37:29]).
REQ-008 deb_bypass_i  input  1  test mode; 1 = debounce skipped.
REQ-009 btn_level_o  output  N_BTN  debounced button level.
REQ-010 btn_press_o  output  N_BTN  one-cycle pulse on each debounced 0->1 transition.
REQ-011 btn_long_o  output  N_BTN  one-cycle pulse when a press has been held LONG_COUNT cycles.
REQ-012 btn_any_o  output  1  OR-reduction of btn_press_o.

Function
REQ-013 Each channel SHALL be independent; no cross-channel state or priority.
REQ-014 Each btn_raw_i bit SHALL pass a 2-flop synchronizer (sync); sync reflects a raw change on the 2nd rising edge after it.
REQ-015 Debounce counter: when sync != btn_level_o, increment by 1; when sync == btn_level_o, clear to 0.
REQ-016 When the counter would reach DEB_COUNT, btn_level_o SHALL take the sync value on that edge and the counter clears to 0.
REQ-017 Net latency, raw step to btn_level_o change: 2 + DEB_COUNT rising edges, given raw held stable throughout.
REQ-018 A glitch shorter than DEB_COUNT sync cycles SHALL leave btn_level_o unchanged and the counter at 0 afterwards.
REQ-019 btn_press_o SHALL be 1 in exactly the cycle in which btn_level_o first reads 1 after reading 0 (registered together); 0 otherwise.
REQ-020 Release (1->0) SHALL produce no pulse on any output.
REQ-021 Hold counter, per channel: cleared while btn_level_o = 0; increments each cycle while btn_level_o = 1; saturates at LONG_COUNT.
REQ-022 btn_long_o SHALL pulse for one cycle on the edge where the hold counter reaches LONG_COUNT, i.e. LONG_COUNT cycles after btn_press_o; at most once per press, no auto-repeat.
REQ-023 Release before LONG_COUNT SHALL clear the hold counter with no btn_long_o pulse.
REQ-024 deb_bypass_i = 1: btn_level_o SHALL follow sync with one register stage; debounce counters held at 0; press and long logic unchanged.
REQ-025 deb_bypass_i changing mid-debounce SHALL NOT glitch btn_press_o; a pulse is emitted only on a real 0->1 transition of btn_level_o.
REQ-026 btn_any_o SHALL be combinational OR of btn_press_o (same cycle).
REQ-027 Counters SHALL never wrap; arithmetic is unsigned CNT_W bits.

Reset
REQ-028 Asserting wb_rst_ni low SHALL immediately clear synchronizers, counters, btn_level_o, btn_press_o, btn_long_o and btn_any_o to 0, independent of the clock.
REQ-029 Reset during a press or debounce SHALL discard all progress; after release, a button already held SHALL be treated as a new press after the full 2 + DEB_COUNT latency.
REQ-030 Reset deassertion SHALL be the only requirement on wb_rst_ni timing; the first active edge after release SHALL see all state at its reset value.

Verification (bench uses DEB_COUNT=4, LONG_COUNT=10, N_BTN=9)
REQ-031 Clean press: btn_raw_i[0] 0->1 held -> btn_level_o[0]=1 and btn_press_o[0]=1 for exactly one cycle, 6 edges after the step; btn_any_o=1 in that same cycle.
REQ-032 Glitch: btn_raw_i[3]=1 for 3 cycles, then 0 -> no change on btn_level_o[3] and no pulse on any output.
REQ-033 Long press: btn_raw_i[8] held 20 cycles after acceptance -> single btn_long_o[8] pulse 10 cycles after btn_press_o[8]; release -> no pulse; press again held 7 cycles -> no btn_long_o.
REQ-034 Simultaneous: btn_raw_i = 9'h1FF stepped together -> all nine btn_press_o bits pulse in the same cycle; btn_any_o=1 for one cycle only.
REQ-035 Bypass: deb_bypass_i=1, btn_raw_i[1] pulse of 1 cycle -> btn_level_o[1] high for one cycle, 3 edges after the step, with one btn_press_o[1] pulse.
REQ-036 Reset mid-hold: btn_raw_i[2] held, wb_rst_ni pulled low between clocks 3 cycles after btn_press_o[2] -> all outputs 0 immediately; after release with the button still held -> new btn_press_o[2] after 6 edges; btn_long_o[2] 10 cycles after that.
